// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - button pin and conditioned event signals
// master drives the raw pin and observes events; slave is the conditioner.
interface button_conditioner_if;
  logic btn_in;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;

  modport master (
    output btn_in,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output long_pulse
  );
endinterface

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchronizer, debounce FSM and press/release/long-press strobes
// All outputs are registered; the pin only reaches the FSM through two flops.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int LONG_CYCLES     = 8000000,
  parameter int CNT_W           = 24,
  parameter int ACTIVE_LOW      = 0
) (
  input logic                clk,
  input logic                rst,
  button_conditioner_if.slave bus
);

  typedef enum logic [2:0] {REL, PDB, PRS, LNG, RDB} state_t;

  localparam logic             INV       = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  state_t             state_q;
  logic               sync1_q, sync2_q;
  logic [CNT_W-1:0]   db_cnt_q, hold_cnt_q;
  logic               long_seen_q;
  logic               level_q, press_q, release_q, long_q;
  logic               n_in;

  assign n_in = bus.btn_in ^ INV;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= REL;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      db_cnt_q    <= '0;
      hold_cnt_q  <= '0;
      long_seen_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      sync1_q   <= n_in;
      sync2_q   <= sync1_q;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      case (state_q)
        REL: begin
          if (sync2_q) begin
            state_q  <= PDB;
            db_cnt_q <= '0;
          end
        end
        PDB: begin
          if (!sync2_q) begin
            state_q <= REL;
          end else if (db_cnt_q == DB_LAST) begin
            state_q     <= PRS;
            press_q     <= 1'b1;
            level_q     <= 1'b1;
            hold_cnt_q  <= '0;
            long_seen_q <= 1'b0;
          end else begin
            db_cnt_q <= db_cnt_q + CNT_W'(1);
          end
        end
        PRS: begin
          // hold_cnt is left untouched on the way to RDB so a bounce resumes timing
          if (!sync2_q) begin
            state_q  <= RDB;
            db_cnt_q <= '0;
          end else if (hold_cnt_q == LONG_LAST) begin
            state_q     <= LNG;
            long_q      <= 1'b1;
            long_seen_q <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q + CNT_W'(1);
          end
        end
        LNG: begin
          if (!sync2_q) begin
            state_q  <= RDB;
            db_cnt_q <= '0;
          end
        end
        RDB: begin
          if (sync2_q) begin
            state_q <= long_seen_q ? LNG : PRS;
          end else if (db_cnt_q == DB_LAST) begin
            state_q     <= REL;
            release_q   <= 1'b1;
            level_q     <= 1'b0;
            long_seen_q <= 1'b0;
          end else begin
            db_cnt_q <= db_cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= REL;
      endcase
    end
  end

  assign bus.btn_level     = level_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.long_pulse    = long_q;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed bench, DEBOUNCE=4 LONG=16, active-high and active-low instances
module tb_button_conditioner;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  button_conditioner_if if0 ();
  button_conditioner_if if1 ();

  button_conditioner #(
    .DEBOUNCE_CYCLES(4), .LONG_CYCLES(16), .CNT_W(8), .ACTIVE_LOW(0)
  ) dut0 (
    .clk(clk), .rst(rst), .bus(if0)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(4), .LONG_CYCLES(16), .CNT_W(8), .ACTIVE_LOW(1)
  ) dut1 (
    .clk(clk), .rst(rst), .bus(if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input bit which, input string tag, input int i,
                            input logic p, input logic r, input logic l, input logic lv);
    logic op, orl, ol, olv;
    op  = which ? if1.press_pulse   : if0.press_pulse;
    orl = which ? if1.release_pulse : if0.release_pulse;
    ol  = which ? if1.long_pulse    : if0.long_pulse;
    olv = which ? if1.btn_level     : if0.btn_level;
    check($sformatf("%s[%0d].press", tag, i), op, p);
    check($sformatf("%s[%0d].release", tag, i), orl, r);
    check($sformatf("%s[%0d].long", tag, i), ol, l);
    check($sformatf("%s[%0d].level", tag, i), olv, lv);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    if0.btn_in = 1'b0;
    if1.btn_in = 1'b1;
    #2;
    check_outs(0, "reset0", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_outs(1, "reset1", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;

    // clean press held 20 cycles, then release
    if0.btn_in = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check_outs(0, "clean", i, (i == 7), 1'b0, 1'b0, (i >= 7));
    end
    if0.btn_in = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check_outs(0, "clean_rel", i, 1'b0, (i == 7), 1'b0, (i < 7));
    end

    // 3-cycle glitch must be rejected
    if0.btn_in = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_outs(0, "bounce", i, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    if0.btn_in = 1'b0;
    for (int i = 4; i <= 12; i++) begin
      tick();
      check_outs(0, "bounce", i, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // long press held 40 cycles
    if0.btn_in = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      check_outs(0, "long", i, (i == 7), 1'b0, (i == 23), (i >= 7));
    end
    if0.btn_in = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check_outs(0, "long_rel", i, 1'b0, (i == 7), 1'b0, (i < 7));
    end

    // release bounce while in LNG
    if0.btn_in = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      check_outs(0, "lng_hold", i, (i == 7), 1'b0, (i == 23), (i >= 7));
    end
    if0.btn_in = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      tick();
      check_outs(0, "lng_bounce", i, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    if0.btn_in = 1'b1;
    for (int i = 3; i <= 22; i++) begin
      tick();
      check_outs(0, "lng_bounce", i, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    if0.btn_in = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check_outs(0, "lng_rel", i, 1'b0, (i == 7), 1'b0, (i < 7));
    end

    // reset while in PRS, button still held afterwards
    if0.btn_in = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check_outs(0, "pre_rst", i, (i == 7), 1'b0, 1'b0, (i >= 7));
    end
    #3;
    rst = 1'b1;
    #1;
    check_outs(0, "async_rst", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_outs(0, "in_rst", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check_outs(0, "post_rst", i, (i == 7), 1'b0, 1'b0, (i >= 7));
    end
    if0.btn_in = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check_outs(0, "post_rst_rel", i, 1'b0, (i == 7), 1'b0, (i < 7));
    end

    // active-low instance: idle high produces nothing, low is a press
    for (int i = 1; i <= 8; i++) begin
      tick();
      check_outs(1, "al_idle", i, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    if1.btn_in = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check_outs(1, "al_press", i, (i == 7), 1'b0, 1'b0, (i >= 7));
    end
    if1.btn_in = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check_outs(1, "al_rel", i, 1'b0, (i == 7), 1'b0, (i < 7));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 200000, number of consecutive stable synchronized samples required to accept a level change.
REQ-002 Parameter: LONG_CYCLES, default 8000000, number of cycles of accepted press before a long-press event.
REQ-003 Parameter: CNT_W, default 24, width of both internal counters.
REQ-004 Parameter: ACTIVE_LOW, default 0, 1 = raw button reads 0 when pressed.
REQ-005 Port: clk  input  1  single system clock, all logic on rising edge.
REQ-006 Port: rst  input  1  asynchronous, active-high reset.
REQ-007 Port: btn_in  input  1  raw, asynchronous, bouncing button pin.
REQ-008 Port: btn_level  output  1  debounced pressed level, 1 = pressed.
REQ-009 Port: press_pulse  output  1  one-cycle strobe on accepted press.
REQ-010 Port: release_pulse  output  1  one-cycle strobe on accepted release.
REQ-011 Port: long_pulse  output  1  one-cycle strobe when press held LONG_CYCLES.

Function
REQ-012 Legal parameters SHALL satisfy 1 <= DEBOUNCE_CYCLES < LONG_CYCLES < 2^CNT_W; other values are unsupported.
REQ-013 Normalized input n = btn_in XOR ACTIVE_LOW SHALL pass through a 2-flop synchronizer; s = second flop output.
REQ-014 All outputs SHALL be registered; no combinational path from btn_in to any output.
REQ-015 FSM states SHALL be REL, PDB (press debounce), PRS, LNG (long held), RDB (release debounce).
REQ-016 REL: s=1 -> PDB with db_cnt=0; else stay.
REQ-017 PDB: s=0 -> REL, no pulse; s=1 and db_cnt=DEBOUNCE_CYCLES-1 -> PRS, press_pulse=1, btn_level=1, hold_cnt=0, long_seen=0; else db_cnt+1.
REQ-018 PRS: s=0 -> RDB with db_cnt=0, hold_cnt frozen; s=1 and hold_cnt=LONG_CYCLES-1 -> LNG, long_pulse=1, long_seen=1; else hold_cnt+1.
REQ-019 LNG: s=0 -> RDB with db_cnt=0; else stay, hold_cnt not incremented.
REQ-020 RDB: s=1 -> LNG if long_seen else PRS (bounce, no pulse, hold_cnt resumes from frozen value); s=0 and db_cnt=DEBOUNCE_CYCLES-1 -> REL, release_pulse=1, btn_level=0, long_seen=0; else db_cnt+1.
REQ-021 Press latency SHALL be exactly DEBOUNCE_CYCLES+3 rising edges from the edge that first samples n=1 (edge 1) to the edge that sets press_pulse; release latency identical for n=0.
REQ-022 long_pulse SHALL assert exactly LONG_CYCLES cycles after press_pulse when no release bounce occurs, and at most once per accepted press.
REQ-023 press_pulse, release_pulse, long_pulse SHALL be mutually exclusive and each high for exactly one cycle.
REQ-024 release_pulse SHALL never occur without a preceding press_pulse; press/release strictly alternate.
REQ-025 Counters SHALL never wrap; every compare uses equality at the terminal value before increment.

Reset
REQ-026 rst=1 SHALL immediately force state REL, synchronizer flops 0, db_cnt=0, hold_cnt=0, long_seen=0, and all four outputs 0, independent of clk.
REQ-027 Reset mid-press SHALL discard the press without release_pulse; if the button is still pressed after rst deasserts, a fresh press_pulse SHALL occur DEBOUNCE_CYCLES+3 edges after the first sampling edge.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=16, ACTIVE_LOW=0)
REQ-028 Clean press: btn_in 0->1 held 20 cycles -> press_pulse one cycle at edge 7, btn_level=1 from edge 7, no long_pulse.
REQ-029 Bounce reject: btn_in high 3 cycles then low -> no pulses, btn_level stays 0, FSM back in REL.
REQ-030 Long press: btn_in held 40 cycles then low -> press_pulse at edge 7, long_pulse exactly 16 cycles later, release_pulse 7 edges after btn_in falls.
REQ-031 Release bounce in LNG: after long_pulse, btn_in low 2 cycles then high -> no release_pulse, no second long_pulse, btn_level stays 1.
REQ-032 Reset mid-press: rst pulsed while in PRS -> all outputs 0 asynchronously; btn_in still 1 -> new press_pulse 7 edges after first post-reset sampling edge.
REQ-033 ACTIVE_LOW=1: btn_in idle 1 after reset -> no events; btn_in 0 held 20 cycles -> press_pulse at edge 7.
